// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic [1:0] {
        SEL_PERIOD = 2'd0,
        SEL_DUTY   = 2'd1,
        SEL_MODE   = 2'd2,
        SEL_RSVD   = 2'd3
    } pwm_sel_e;

    localparam int DEFAULT_CHANNELS    = 4;
    localparam int DEFAULT_PERIOD_BITS = 16;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: delays each rising edge of the high and low side by dt clocks.
// Only built when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
    parameter int DT_BITS = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               en,
    input  logic               r,
    input  logic [DT_BITS-1:0] dt,
    output logic               hi,
    output logic               lo
);

    logic               r_q;
    logic [DT_BITS-1:0] run;
    logic [DT_BITS-1:0] stable;

    // Cycles the raw bit has held its current value before this one; zero on the cycle it toggles.
    assign stable = (r == r_q) ? run : '0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_q <= 1'b0;
            run <= '0;
            hi  <= 1'b0;
            lo  <= 1'b0;
        end else if (!en) begin
            r_q <= 1'b0;
            run <= '0;
            hi  <= 1'b0;
            lo  <= 1'b0;
        end else begin
            r_q <= r;
            if (r != r_q)
                run <= DT_BITS'(1);
            else if (run != '1)
                run <= run + DT_BITS'(1);
            hi <= r && (stable >= dt);
            lo <= !r && (stable >= dt);
        end
    end

endmodule
`endif

// File: rtl/multi_channel_pwm.sv
// N-channel PWM with a shared period counter and shadow/active registers loaded at the period boundary.
// Optional dead-time outputs are enabled with the PWM_DEADTIME_EN macro.
module multi_channel_pwm
    import pwm_pkg::*;
#(
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int PERIOD_BITS = DEFAULT_PERIOD_BITS,
    parameter int DT_BITS     = 4
) (
    input  logic                                               Clk,
    input  logic                                               Rst,
    input  logic                                               En,
    input  logic                                               cfg_wr,
    input  logic [1:0]                                         cfg_sel,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [PERIOD_BITS-1:0]                             cfg_data,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_BITS-1:0]                                 dt_i,
    output logic [CHANNELS-1:0]                                pwm_n_o,
`endif
    output logic [CHANNELS-1:0]                                pwm_o,
    output logic                                               period_end
);

    logic [PERIOD_BITS-1:0] cnt_p0;
    logic                   dir_down_p0;
    logic [PERIOD_BITS-1:0] period_sh;
    logic [PERIOD_BITS-1:0] period_act;
    logic [PERIOD_BITS-1:0] duty_sh  [CHANNELS];
    logic [PERIOD_BITS-1:0] duty_act [CHANNELS];
    pwm_mode_e              mode_sh;
    pwm_mode_e              mode_act;
    logic [CHANNELS-1:0]    pwm_p1;
    logic                   upd;
    logic                   load;
    logic                   restart;

    assign upd = (period_act == '0)
              || ((mode_act == PWM_EDGE)   && (cnt_p0 == period_act))
              || ((mode_act == PWM_CENTER) && dir_down_p0 && (cnt_p0 == '0));

    // While stopped the active set tracks the shadows so a restart uses the latest configuration.
    assign load = !En || upd;

    // A new period starts from 0 counting up when the mode flips or either period is zero.
    assign restart = upd && ((period_sh == '0) || (period_act == '0) || (mode_sh != mode_act));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            period_sh <= '0;
            mode_sh   <= PWM_EDGE;
            for (int i = 0; i < CHANNELS; i++)
                duty_sh[i] <= '0;
        end else if (cfg_wr) begin
            case (cfg_sel)
                SEL_PERIOD: period_sh <= cfg_data;
                SEL_DUTY: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (int'(cfg_ch) == i)
                            duty_sh[i] <= cfg_data;
                end
                SEL_MODE:   mode_sh <= pwm_mode_e'(cfg_data[0]);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            period_act <= '0;
            mode_act   <= PWM_EDGE;
            for (int i = 0; i < CHANNELS; i++)
                duty_act[i] <= '0;
        end else if (load) begin
            period_act <= period_sh;
            mode_act   <= mode_sh;
            for (int i = 0; i < CHANNELS; i++)
                duty_act[i] <= duty_sh[i];
        end
    end

    // Stage p0: shared period counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_p0      <= '0;
            dir_down_p0 <= 1'b0;
        end else if (!En || restart) begin
            cnt_p0      <= '0;
            dir_down_p0 <= 1'b0;
        end else if (mode_act == PWM_EDGE) begin
            dir_down_p0 <= 1'b0;
            cnt_p0      <= (cnt_p0 == period_act) ? '0 : cnt_p0 + PERIOD_BITS'(1);
        end else if (!dir_down_p0) begin
            if (cnt_p0 == period_act) begin
                cnt_p0      <= cnt_p0 - PERIOD_BITS'(1);
                dir_down_p0 <= 1'b1;
            end else begin
                cnt_p0 <= cnt_p0 + PERIOD_BITS'(1);
            end
        end else if (cnt_p0 == '0) begin
            cnt_p0      <= PERIOD_BITS'(1);
            dir_down_p0 <= 1'b0;
        end else begin
            cnt_p0 <= cnt_p0 - PERIOD_BITS'(1);
        end
    end

    // Stage p1: registered compare and boundary pulse
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pwm_p1     <= '0;
            period_end <= 1'b0;
        end else begin
            period_end <= En && upd;
            for (int i = 0; i < CHANNELS; i++)
                pwm_p1[i] <= En && (cnt_p0 < duty_act[i]);
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_BITS-1:0] dt_act;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            dt_act <= '0;
        else if (load)
            dt_act <= dt_i;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
        pwm_deadtime #(
            .DT_BITS (DT_BITS)
        ) u_deadtime (
            .Clk (Clk),
            .Rst (Rst),
            .en  (En),
            .r   (pwm_p1[g]),
            .dt  (dt_act),
            .hi  (pwm_o[g]),
            .lo  (pwm_n_o[g])
        );
    end
`else
    assign pwm_o = pwm_p1;

    if (DT_BITS < 1) begin : g_dt_bits_invalid
    end
`endif

endmodule
